datamem_sync: RTL and testbench
===============================

# datamem_sync

Parametrised synchronous data memory that succeeds the fixed 20×16 data memory. It sits between the datapath load/store stage and the register write-back mux. The block adds a valid/ready request port, byte-enable writes, a configurable read-latency pipeline, out-of-range detection and a hardware zero-initialisation sequence after reset. Every accepted request, read or write, returns exactly one in-order response.

## Interface
- DATA_W, 16, word width in bits; must be a multiple of 8
- ADDR_W, 16, request address width
- DEPTH, 32, number of words; 1 ≤ DEPTH ≤ 2^ADDR_W
- RD_LAT, 1, response latency in cycles; legal range 1..4
- INIT_ZERO, 1, 1 = clear all words after reset, 0 = skip the clear
- clk  in  1  clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- req_be  in  DATA_W/8  byte enables for writes; ignored on reads
- rsp_valid  out  1  response valid, one-cycle pulse per request
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  address ≥ DEPTH
- busy  out  1  initialisation in progress

## Operation
- FSM states are ST_INIT and ST_RUN.
- Reset asserted: state = ST_INIT, init counter = 0, all pipeline valids = 0.
- Reset outputs: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=1.
- ST_INIT with INIT_ZERO=1: write 0 to word[cnt] each cycle. After word DEPTH-1 is written, go to ST_RUN.
- ST_INIT with INIT_ZERO=0: go to ST_RUN on the first clock edge; memory contents are undefined.
- ST_RUN: req_ready=1 and busy=0, permanently. There is no response backpressure.
- Handshake: a request is accepted on an edge where req_valid && req_ready is true. At most one request is accepted per cycle.
- Accepted write, in range: byte i of word[addr] is updated where req_be[i]=1; other bytes keep their value. The response carries rdata=0 and err=0.
- Accepted read, in range: word[addr] is sampled at the accept edge. The sample includes any write accepted on an earlier edge.
- Out of range (addr ≥ DEPTH, compared at full ADDR_W width): a write is dropped and memory is unchanged; a read returns 0. Both give err=1.
- Responses leave in acceptance order through an RD_LAT-deep shift pipeline of {valid, rdata, err}.
- Reset mid-operation: in-flight responses are discarded immediately. No stale response appears after reset. With INIT_ZERO=1, initialisation reruns.

## Timing
- Request accepted at edge E0 → rsp_valid/rsp_rdata/rsp_err are registered at edge E(RD_LAT) and held for exactly one cycle.
- Back-to-back requests give back-to-back responses, with throughput of 1 per cycle.
- Write at E0 followed by a read of the same address at E1: the read returns the new data.
- Initialisation from rst_n deassertion to req_ready=1 takes DEPTH cycles when INIT_ZERO=1 and 1 cycle when INIT_ZERO=0.
- busy falls on the same edge that req_ready rises.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Package datamem_pkg holds:
  - state typedef {ST_INIT, ST_RUN}
  - localparam MAX_RD_LAT=4
  - function be_merge(old, wdata, be)
- Sub-module datamem_pipe(W, LAT): valid-tagged delay line, async-clear of valids on rst_n, carries {err, rdata}.
- Elaboration-time checks: DATA_W%8==0, 1≤RD_LAT≤MAX_RD_LAT, DEPTH≤2^ADDR_W.

## Test plan
- Init, default parameters:
  - release rst_n → busy=1 and req_ready=0 for 32 cycles, then both flip.
  - read addr 11 → rsp_rdata=0x0000, err=0, one cycle later.
- Write, then read:
  - write 0x0014 to addr 14 with be=2'b11, then read addr 14 on the next cycle.
  - write response rdata=0, err=0; read response 0x0014.
- Byte enable:
  - write 0xABCD to addr 14 with be=2'b01, then read.
  - read returns 0x00CD.
- Out of range:
  - write 0x1234 to addr 40 → err=1.
  - read addr 40 → rdata=0, err=1.
  - a full scan of words 0..31 is unchanged.
- RD_LAT=3:
  - back-to-back reads of addrs 1, 2, 3, each preloaded with 0x0001..0x0003.
  - rsp_valid is high 3 cycles after each accept, on consecutive cycles, in order.
- Reset mid-flight, RD_LAT=3:
  - pull rst_n low with 2 reads pending → rsp_valid=0 immediately.
  - no response appears after release; busy reasserts for 32 cycles.

Source files
------------

// File: rtl/datamem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : datamem_pkg
// Purpose  : Shared types, limits and helpers for the datamem_sync memory.
//            - state_t     : controller states (ST_INIT, ST_RUN)
//            - MAX_RD_LAT  : largest supported response latency
//            - MAX_DATA_W  : widest word be_merge can handle
//            - be_merge()  : byte-enable merge of write data into a word
// Revision : 1.0 - initial release
// ============================================================================
package datamem_pkg;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int MAX_RD_LAT = 4;

   // be_merge works on a fixed maximum width; callers zero-extend their
   // operands and truncate the result back to their own word width.
   localparam int MAX_DATA_W = 128;
   localparam int MAX_BE_W   = MAX_DATA_W / 8;

   function automatic logic [MAX_DATA_W-1:0] be_merge(
      input logic [MAX_DATA_W-1:0] old,
      input logic [MAX_DATA_W-1:0] wdata,
      input logic [MAX_BE_W-1:0]   be
   );
      logic [MAX_DATA_W-1:0] res;
      res = old;
      for (int i = 0; i < MAX_BE_W; i++) begin
         if (be[i]) begin
            res[8*i +: 8] = wdata[8*i +: 8];
         end
      end
      return res;
   endfunction

endpackage : datamem_pkg
`default_nettype wire

// File: rtl/datamem_pipe.sv
`default_nettype none
// ============================================================================
// Module   : datamem_pipe
// Purpose  : Valid-tagged delay line of LAT register stages. Valid bits and
//            payload are cleared asynchronously so nothing in flight survives
//            a reset.
// Ports    : clk_i     clock
//            rst_n_i   asynchronous active-low reset
//            valid_i   stage-0 valid input
//            data_i    stage-0 payload input ({err, rdata} in datamem_sync)
//            valid_o   valid leaving the last stage
//            data_o    payload leaving the last stage
// Revision : 1.0 - initial release
// ============================================================================
module datamem_pipe #(
   parameter int W   = 17,
   parameter int LAT = 2
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         valid_i,
   input  logic [W-1:0] data_i,
   output logic         valid_o,
   output logic [W-1:0] data_o
);

   logic [LAT-1:0]        valid_q;
   logic [LAT-1:0][W-1:0] data_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         valid_q <= '0;
         data_q  <= '0;
      end else begin
         valid_q[0] <= valid_i;
         data_q[0]  <= data_i;
         for (int i = 1; i < LAT; i++) begin
            valid_q[i] <= valid_q[i-1];
            data_q[i]  <= data_q[i-1];
         end
      end
   end

   assign valid_o = valid_q[LAT-1];
   assign data_o  = data_q[LAT-1];

endmodule : datamem_pipe
`default_nettype wire

// File: rtl/datamem_sync.sv
`default_nettype none
// ============================================================================
// Module   : datamem_sync
// Purpose  : Parametrised synchronous data memory with valid/ready request
//            port, byte-enable writes, RD_LAT-cycle in-order responses,
//            out-of-range detection and optional zero-fill after reset.
// Ports    : clk_i         clock
//            rst_n_i       asynchronous active-low reset
//            req_valid_i   request present
//            req_ready_o   request can be accepted (high in ST_RUN)
//            req_we_i      1 = write, 0 = read
//            req_addr_i    word address
//            req_wdata_i   write data
//            req_be_i      write byte enables
//            rsp_valid_o   one-cycle response pulse per accepted request
//            rsp_rdata_o   read data (0 for writes and errors)
//            rsp_err_o     address was >= DEPTH
//            busy_o        initialisation in progress
// Revision : 1.0 - initial release
// ============================================================================
module datamem_sync
   import datamem_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 16,
   parameter int DEPTH     = 32,
   parameter int RD_LAT    = 1,
   parameter int INIT_ZERO = 1
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic                req_we_i,
   input  logic [ADDR_W-1:0]   req_addr_i,
   input  logic [DATA_W-1:0]   req_wdata_i,
   input  logic [DATA_W/8-1:0] req_be_i,
   output logic                rsp_valid_o,
   output logic [DATA_W-1:0]   rsp_rdata_o,
   output logic                rsp_err_o,
   output logic                busy_o
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // One bit wider than the address so DEPTH == 2**ADDR_W is representable.
   localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W+1)'(DEPTH);
   localparam logic [IDX_W-1:0] CNT_LAST  = IDX_W'(DEPTH - 1);

   // ------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ------------------------------------------------------------------
   if (DATA_W % 8 != 0) begin : g_chk_data_w
      $error("datamem_sync: DATA_W must be a multiple of 8");
   end
   if (DATA_W > MAX_DATA_W) begin : g_chk_data_max
      $error("datamem_sync: DATA_W exceeds MAX_DATA_W");
   end
   if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT) begin : g_chk_rd_lat
      $error("datamem_sync: RD_LAT out of range 1..MAX_RD_LAT");
   end
   if (DEPTH < 1 || DEPTH > (2 ** ADDR_W)) begin : g_chk_depth
      $error("datamem_sync: DEPTH must satisfy 1 <= DEPTH <= 2**ADDR_W");
   end

   // ------------------------------------------------------------------
   // Controller FSM
   // ------------------------------------------------------------------
   state_t           state_q, state_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic             w_init_we;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      w_init_we = 1'b0;
      case (state_q)
         ST_INIT: begin
            if (INIT_ZERO != 0) begin
               w_init_we = 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   // Decoded straight from the state flop, so both are register outputs and
   // change on the same edge.
   assign req_ready_o = (state_q == ST_RUN);
   assign busy_o      = (state_q == ST_INIT);

   // ------------------------------------------------------------------
   // Request decode
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              w_accept;
   logic              w_in_range;
   logic [IDX_W-1:0]  w_idx;
   logic [DATA_W-1:0] w_rd_word;
   logic [DATA_W-1:0] w_merged;
   logic              w_mem_we;
   logic [DATA_W-1:0] w_rsp_rdata;

   assign w_accept   = req_valid_i && (state_q == ST_RUN);
   // Full-width compare: high address bits must never alias into range.
   assign w_in_range = ({1'b0, req_addr_i} < DEPTH_EXT);
   assign w_idx      = req_addr_i[IDX_W-1:0];
   assign w_rd_word  = mem_q[w_idx];
   assign w_merged   = DATA_W'(be_merge(MAX_DATA_W'(w_rd_word),
                                        MAX_DATA_W'(req_wdata_i),
                                        MAX_BE_W'(req_be_i)));
   assign w_mem_we   = w_accept && req_we_i && w_in_range;
   assign w_rsp_rdata = (!req_we_i && w_in_range) ? w_rd_word : '0;

   // Storage has no reset; zero-fill is done by the ST_INIT sweep instead.
   always_ff @(posedge clk_i) begin
      if (w_init_we) begin
         mem_q[cnt_q] <= '0;
      end else if (w_mem_we) begin
         mem_q[w_idx] <= w_merged;
      end
   end

   // ------------------------------------------------------------------
   // Response pipeline. Stage 0 is the sample taken at the accept edge; the
   // remaining RD_LAT stages deliver it RD_LAT edges later.
   // ------------------------------------------------------------------
   logic [DATA_W:0] w_pipe_out;

   datamem_pipe #(
      .W   (DATA_W + 1),
      .LAT (RD_LAT + 1)
   ) u_pipe (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .valid_i (w_accept),
      .data_i  ({!w_in_range, w_rsp_rdata}),
      .valid_o (rsp_valid_o),
      .data_o  (w_pipe_out)
   );

   assign rsp_err_o   = w_pipe_out[DATA_W];
   assign rsp_rdata_o = w_pipe_out[DATA_W-1:0];

endmodule : datamem_sync
`default_nettype wire

// File: tb/tb_datamem_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_datamem_sync
// Purpose  : Directed self-checking bench for datamem_sync. Three instances:
//            u_dut1 (defaults, RD_LAT=1), u_dut3 (RD_LAT=3, own reset) and
//            u_dut0 (INIT_ZERO=0, DEPTH=20, idle).
// Revision : 1.0 - initial release
// ============================================================================
module tb_datamem_sync;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic rst3  = 1'b1;

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // DUT1 (RD_LAT=1)
   logic        valid1 = 1'b0, we1 = 1'b0;
   logic [15:0] addr1 = '0, wdata1 = '0;
   logic [1:0]  be1 = '0;
   logic        ready1, rsp_valid1, rsp_err1, busy1;
   logic [15:0] rsp_rdata1;

   // DUT3 (RD_LAT=3)
   logic        valid3 = 1'b0, we3 = 1'b0;
   logic [15:0] addr3 = '0, wdata3 = '0;
   logic [1:0]  be3 = '0;
   logic        ready3, rsp_valid3, rsp_err3, busy3;
   logic [15:0] rsp_rdata3;

   // DUT0 (INIT_ZERO=0), inputs idle
   logic        valid0 = 1'b0, we0 = 1'b0;
   logic [15:0] addr0 = '0, wdata0 = '0;
   logic [1:0]  be0 = '0;
   logic        ready0, rsp_valid0, rsp_err0, busy0;
   logic [15:0] rsp_rdata0;

   datamem_sync u_dut1 (
      .clk_i(clk), .rst_n_i(rst_n),
      .req_valid_i(valid1), .req_ready_o(ready1), .req_we_i(we1),
      .req_addr_i(addr1), .req_wdata_i(wdata1), .req_be_i(be1),
      .rsp_valid_o(rsp_valid1), .rsp_rdata_o(rsp_rdata1),
      .rsp_err_o(rsp_err1), .busy_o(busy1)
   );

   datamem_sync #(.RD_LAT(3)) u_dut3 (
      .clk_i(clk), .rst_n_i(rst3),
      .req_valid_i(valid3), .req_ready_o(ready3), .req_we_i(we3),
      .req_addr_i(addr3), .req_wdata_i(wdata3), .req_be_i(be3),
      .rsp_valid_o(rsp_valid3), .rsp_rdata_o(rsp_rdata3),
      .rsp_err_o(rsp_err3), .busy_o(busy3)
   );

   datamem_sync #(.DEPTH(20), .INIT_ZERO(0)) u_dut0 (
      .clk_i(clk), .rst_n_i(rst_n),
      .req_valid_i(valid0), .req_ready_o(ready0), .req_we_i(we0),
      .req_addr_i(addr0), .req_wdata_i(wdata0), .req_be_i(be0),
      .rsp_valid_o(rsp_valid0), .rsp_rdata_o(rsp_rdata0),
      .rsp_err_o(rsp_err0), .busy_o(busy0)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One isolated request on DUT1 with full response timing checks.
   task automatic single1(input logic we, input logic [15:0] a, input logic [15:0] wd,
                          input logic [1:0] be, input logic [15:0] exp_d,
                          input logic exp_e, input string tag);
      valid1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd; be1 = be;
      tick();
      valid1 = 1'b0;
      check({tag, " early"}, rsp_valid1, 0);
      tick();
      check({tag, " valid"}, rsp_valid1, 1);
      check({tag, " rdata"}, rsp_rdata1, exp_d);
      check({tag, " err"},   rsp_err1,   exp_e);
      tick();
      check({tag, " pulse"}, rsp_valid1, 0);
   endtask

   initial begin
      int c1, c3, c0, mm, stale;
      logic [15:0] exp_w;

      // ---------------- reset state ----------------
      #2;
      rst_n = 1'b0;
      rst3  = 1'b0;
      repeat (3) tick();
      check("rst ready1", ready1, 0);
      check("rst busy1",  busy1, 1);
      check("rst valid1", rsp_valid1, 0);
      check("rst rdata1", rsp_rdata1, 0);
      check("rst err1",   rsp_err1, 0);
      check("rst ready3", ready3, 0);
      check("rst busy3",  busy3, 1);
      check("rst busy0",  busy0, 1);

      // ---------------- init duration ----------------
      rst_n = 1'b1;
      rst3  = 1'b1;
      c1 = 0; c3 = 0; c0 = 0; mm = 0;
      for (int c = 1; c <= 100; c++) begin
         tick();
         if (ready1 && c1 == 0) c1 = c;
         if (ready3 && c3 == 0) c3 = c;
         if (ready0 && c0 == 0) c0 = c;
         if (busy1 == ready1) mm++;
         if (c1 != 0 && c3 != 0 && c0 != 0) break;
      end
      check("init cycles dut1", c1, 32);
      check("init cycles dut3", c3, 32);
      check("init cycles dut0", c0, 1);
      check("busy vs ready", mm, 0);
      check("busy1 low", busy1, 0);

      // ---------------- DUT1 functional ----------------
      single1(1'b0, 16'd11, 16'h0000, 2'b00, 16'h0000, 1'b0, "rd11");

      // write then read on consecutive cycles
      valid1 = 1'b1; we1 = 1'b1; addr1 = 16'd14; wdata1 = 16'h0014; be1 = 2'b11;
      tick();
      we1 = 1'b0; wdata1 = 16'h0000;
      tick();
      valid1 = 1'b0;
      check("b2b wr valid", rsp_valid1, 1);
      check("b2b wr rdata", rsp_rdata1, 16'h0000);
      check("b2b wr err",   rsp_err1, 0);
      tick();
      check("b2b rd valid", rsp_valid1, 1);
      check("b2b rd rdata", rsp_rdata1, 16'h0014);
      check("b2b rd err",   rsp_err1, 0);
      tick();
      check("b2b pulse", rsp_valid1, 0);

      single1(1'b1, 16'd14, 16'hABCD, 2'b01, 16'h0000, 1'b0, "wr be01");
      single1(1'b0, 16'd14, 16'h0000, 2'b00, 16'h00CD, 1'b0, "rd be01");
      single1(1'b1, 16'd3,  16'hAB12, 2'b10, 16'h0000, 1'b0, "wr be10");
      single1(1'b0, 16'd3,  16'h0000, 2'b00, 16'hAB00, 1'b0, "rd be10");

      single1(1'b1, 16'd40,   16'h1234, 2'b11, 16'h0000, 1'b1, "wr oor40");
      single1(1'b0, 16'd40,   16'h0000, 2'b00, 16'h0000, 1'b1, "rd oor40");
      single1(1'b0, 16'd32,   16'h0000, 2'b00, 16'h0000, 1'b1, "rd oor32");
      single1(1'b1, 16'h8003, 16'h5555, 2'b11, 16'h0000, 1'b1, "wr oor8003");
      single1(1'b1, 16'd35,   16'h7777, 2'b11, 16'h0000, 1'b1, "wr oor35");

      for (int i = 0; i < 32; i++) begin
         exp_w = (i == 14) ? 16'h00CD : (i == 3) ? 16'hAB00 : 16'h0000;
         single1(1'b0, 16'(i), 16'h0000, 2'b00, exp_w, 1'b0, $sformatf("scan%0d", i));
      end

      // ---------------- DUT3 RD_LAT=3 ----------------
      for (int k = 1; k <= 3; k++) begin
         valid3 = 1'b1; we3 = 1'b1; addr3 = 16'(k); wdata3 = 16'(k); be3 = 2'b11;
         tick();
      end
      valid3 = 1'b0; we3 = 1'b0;
      repeat (6) tick();

      for (int k = 0; k < 7; k++) begin
         if (k < 3) begin
            valid3 = 1'b1; we3 = 1'b0; addr3 = 16'(k + 1);
         end else begin
            valid3 = 1'b0;
         end
         tick();
         if (k >= 3 && k <= 5) begin
            check($sformatf("lat3 valid e%0d", k), rsp_valid3, 1);
            check($sformatf("lat3 rdata e%0d", k), rsp_rdata3, 32'(k - 2));
            check($sformatf("lat3 err e%0d", k),   rsp_err3, 0);
         end else begin
            check($sformatf("lat3 idle e%0d", k), rsp_valid3, 0);
         end
      end

      // ---------------- reset mid-flight on DUT3 ----------------
      for (int k = 0; k < 3; k++) begin
         valid3 = 1'b1; we3 = 1'b0; addr3 = 16'(k + 1);
         tick();
      end
      valid3 = 1'b0;
      tick();
      check("mid first valid", rsp_valid3, 1);
      check("mid first rdata", rsp_rdata3, 16'h0001);
      #1;
      rst3 = 1'b0;
      #1;
      check("mid rst valid", rsp_valid3, 0);
      check("mid rst rdata", rsp_rdata3, 0);
      check("mid rst ready", ready3, 0);
      check("mid rst busy",  busy3, 1);
      repeat (2) tick();
      rst3 = 1'b1;
      c3 = 0; stale = 0;
      for (int c = 1; c <= 60; c++) begin
         tick();
         if (rsp_valid3) stale++;
         if (ready3 && c3 == 0) c3 = c;
      end
      check("mid stale rsp", stale, 0);
      check("mid reinit cycles", c3, 32);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Guard against a hung run.
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule : tb_datamem_sync
`default_nettype wire
